// File: rtl/lap_time_bcd.sv
// Round-robin binary-to-BCD converter for the lap timer's current/last/best times.
// A single shift-add-3 engine serves all channels; each result is held until that channel's next refresh.
module lap_time_bcd #(
  parameter int CH_COUNT = 3,
  parameter int BIN_W    = 16,
  parameter int BCD_W    = 20
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  input  logic [BIN_W-1:0] current_lap_time,
  input  logic [BIN_W-1:0] last_lap_time,
  input  logic [BIN_W-1:0] best_lap_time,
  output logic [BCD_W-1:0] current_lap_bcd,
  output logic [BCD_W-1:0] last_lap_bcd,
  output logic [BCD_W-1:0] best_lap_bcd,
  output logic             busy,
  output logic             frame_done
);

  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int DIGITS = BCD_W / 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [1:0]          idx_r;
  logic [WORK_W-1:0]   work_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [BIN_W-1:0]    sel_s;
  logic                last_ch_s;
  logic                shift_end_s;

  // One double-dabble iteration: correct every BCD digit >= 5, then shift the whole word left.
  function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] t;
    t = w;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[BIN_W + 4*d +: 4] >= 4'd5) begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4] + 4'd3;
      end else begin
        t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d +: 4];
      end
    end
    return {t[WORK_W-2:0], 1'b0};
  endfunction

  // Channel input select and end-of-iteration / end-of-frame flags.
  always_comb begin
    sel_s       = best_lap_time;
    last_ch_s   = (idx_r == 2'(CH_COUNT - 1));
    shift_end_s = (cnt_r == CNT_W'(BIN_W - 1));
    case (idx_r)
      2'd0:    sel_s = current_lap_time;
      2'd1:    sel_s = last_lap_time;
      2'd2:    sel_s = best_lap_time;
      default: sel_s = best_lap_time;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        state_s = SHIFT;
      end
      SHIFT: begin
        if (shift_end_s) begin
          state_s = STORE;
        end else begin
          state_s = SHIFT;
        end
      end
      STORE: begin
        if (en) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; busy and frame_done are registered from the next state so they track it exactly.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy       <= (state_s != IDLE);
      frame_done <= (state_s == STORE) && last_ch_s;
    end
  end

  // Conversion datapath, channel index and held BCD results.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      work_r          <= {WORK_W{1'b0}};
      cnt_r           <= {CNT_W{1'b0}};
      idx_r           <= 2'd0;
      current_lap_bcd <= {BCD_W{1'b0}};
      last_lap_bcd    <= {BCD_W{1'b0}};
      best_lap_bcd    <= {BCD_W{1'b0}};
    end else begin
      case (state_r)
        LOAD: begin
          work_r <= {{BCD_W{1'b0}}, sel_s};
          cnt_r  <= {CNT_W{1'b0}};
        end
        SHIFT: begin
          work_r <= dabble_step(work_r);
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        STORE: begin
          case (idx_r)
            2'd0:    current_lap_bcd <= work_r[WORK_W-1:BIN_W];
            2'd1:    last_lap_bcd    <= work_r[WORK_W-1:BIN_W];
            2'd2:    best_lap_bcd    <= work_r[WORK_W-1:BIN_W];
            default: best_lap_bcd    <= work_r[WORK_W-1:BIN_W];
          endcase
          if (last_ch_s) begin
            idx_r <= 2'd0;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        default: begin
          work_r <= work_r;
        end
      endcase
    end
  end

endmodule
